// File: rtl/greater_than_pkg.sv
// Shared constants and result type for the greater_than comparator.
// The signed compare is enabled by defining GREATER_THAN_SIGNED_EN.
package greater_than_pkg;

    localparam int GT_WIDTH_DEFAULT = 2;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_res_t;

    localparam cmp_res_t CMP_RES_NONE = '{gt: 1'b0, eq: 1'b0, lt: 1'b0};

    // Less-than is whatever is left once greater and equal are ruled out.
    function automatic cmp_res_t make_res(input logic gt, input logic eq);
        return '{gt: gt, eq: eq, lt: ~(gt | eq)};
    endfunction

endpackage

// File: rtl/gt_bit_cell.sv
// One stage of the MSB-to-LSB magnitude-compare cascade.
module gt_bit_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic gt_i,
    input  logic eq_i,
    output logic gt_o,
    output logic eq_o
);

    // A bit only decides the result while every more-significant bit tied.
    assign gt_o = gt_i | (eq_i & a_i & ~b_i);
    assign eq_o = eq_i & ~(a_i ^ b_i);

endmodule

// File: rtl/greater_than.sv
// Registered A-vs-B comparator (F/EQ/LT) with a one-cycle valid pipeline.
// Define GREATER_THAN_SIGNED_EN for a two's-complement compare; default is unsigned.
module greater_than
    import greater_than_pkg::*;
#(
    parameter int WIDTH = GT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic             F,
    output logic             EQ,
    output logic             LT,
    output logic             out_valid
);

    logic [WIDTH-1:0] a_cmp;
    logic [WIDTH-1:0] b_cmp;
    logic [WIDTH:0]   gt_c;
    logic [WIDTH:0]   eq_c;
    cmp_res_t         res_d;
    cmp_res_t         res_q;
    logic             vld_d;
    logic             vld_q;

`ifdef GREATER_THAN_SIGNED_EN
    // Inverting the sign bits maps two's-complement order onto unsigned order.
    always_comb begin
        a_cmp            = A;
        b_cmp            = B;
        a_cmp[WIDTH-1]   = ~A[WIDTH-1];
        b_cmp[WIDTH-1]   = ~B[WIDTH-1];
    end
`else
    assign a_cmp = A;
    assign b_cmp = B;
`endif

    assign gt_c[WIDTH] = 1'b0;
    assign eq_c[WIDTH] = 1'b1;

    for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_cell
        gt_bit_cell u_cell (
            .a_i  (a_cmp[i]),
            .b_i  (b_cmp[i]),
            .gt_i (gt_c[i+1]),
            .eq_i (eq_c[i+1]),
            .gt_o (gt_c[i]),
            .eq_o (eq_c[i])
        );
    end

    assign res_d = make_res(gt_c[0], eq_c[0]);
    assign vld_d = in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= CMP_RES_NONE;
            vld_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            if (in_valid) begin
                res_q <= res_d;
            end
        end
    end

    assign F         = res_q.gt;
    assign EQ        = res_q.eq;
    assign LT        = res_q.lt;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_greater_than.sv
// Directed, table-driven bench for greater_than at WIDTH=2 and WIDTH=8.
module tb_greater_than;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] a2, b2;
    logic       v2;
    logic       f2, eq2, lt2, ov2;
    logic [7:0] a8, b8;
    logic       v8;
    logic       f8, eq8, lt8, ov8;

    int n_checks = 0;
    int n_fail   = 0;

    greater_than #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .A(a2), .B(b2), .in_valid(v2),
        .F(f2), .EQ(eq2), .LT(lt2), .out_valid(ov2)
    );

    greater_than #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .in_valid(v8),
        .F(f8), .EQ(eq8), .LT(lt8), .out_valid(ov8)
    );

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] exp;
    } vec_t;

    vec_t vecs[16];

    // Reference compare on integers: {gt, eq, lt}.
    function automatic logic [2:0] model(input logic [7:0] a, input logic [7:0] b, input int w);
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
`ifdef GREATER_THAN_SIGNED_EN
        if (a[w-1]) sa = sa - (1 << w);
        if (b[w-1]) sb = sb - (1 << w);
`endif
        return {sa > sb, sa == sb, sa < sb};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {F,EQ,LT,out_valid}=%b, expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] exp_hold;

    initial begin
        rst = 1'b1;
        a2 = 2'd0; b2 = 2'd0; v2 = 1'b0;
        a8 = 8'd0; b8 = 8'd0; v8 = 1'b0;

        for (int i = 0; i < 16; i++) begin
            vecs[i].a   = i[3:2];
            vecs[i].b   = i[1:0];
            vecs[i].exp = model({6'd0, i[3:2]}, {6'd0, i[1:0]}, 2);
        end

        // Reset is asynchronous: outputs must be clear before any clock edge.
        #1;
        check("reset_async_w2", {f2, eq2, lt2, ov2}, 4'b0000);
        check("reset_async_w8", {f8, eq8, lt8, ov8}, 4'b0000);
        v2 = 1'b1; a2 = 2'd3; b2 = 2'd0;
        tick();
        check("reset_held_w2", {f2, eq2, lt2, ov2}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        v2  = 1'b0;

        // Exhaustive back-to-back sweep at WIDTH=2.
        for (int i = 0; i < 16; i++) begin
            a2 = vecs[i].a;
            b2 = vecs[i].b;
            v2 = 1'b1;
            tick();
            check($sformatf("exh a=%0d b=%0d", vecs[i].a, vecs[i].b),
                  {f2, eq2, lt2, ov2}, {vecs[i].exp, 1'b1});
        end

        a2 = 2'd3; b2 = 2'd3; v2 = 1'b1;
        tick();
        check("equal_3_3", {f2, eq2, lt2, ov2}, 4'b0101);

        a2 = 2'b10; b2 = 2'b01; v2 = 1'b1;
        tick();
`ifdef GREATER_THAN_SIGNED_EN
        check("sign_m2_vs_p1", {f2, eq2, lt2, ov2}, 4'b0011);
`else
        check("sign_m2_vs_p1", {f2, eq2, lt2, ov2}, 4'b1001);
`endif

        // Hold: an idle edge keeps the last result and drops out_valid.
        exp_hold = model(8'd1, 8'd2, 2);
        a2 = 2'd1; b2 = 2'd2; v2 = 1'b1;
        tick();
        check("hold_load", {f2, eq2, lt2, ov2}, {exp_hold, 1'b1});
        a2 = 2'd3; b2 = 2'd0; v2 = 1'b0;
        tick();
        check("hold_idle", {f2, eq2, lt2, ov2}, {exp_hold, 1'b0});
        tick();
        check("hold_idle2", {f2, eq2, lt2, ov2}, {exp_hold, 1'b0});

        // Mid-stream reset between edges while F=1.
        a2 = 2'd1; b2 = 2'd0; v2 = 1'b1;
        tick();
        check("pre_reset_f", {f2, eq2, lt2, ov2}, 4'b1001);
        #2;
        rst = 1'b1;
        #1;
        check("reset_mid_async", {f2, eq2, lt2, ov2}, 4'b0000);
        tick();
        check("reset_mid_held", {f2, eq2, lt2, ov2}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        v2  = 1'b0;
        tick();
        check("post_reset_idle", {f2, eq2, lt2, ov2}, 4'b0000);
        v2 = 1'b1;
        tick();
        check("post_reset_first", {f2, eq2, lt2, ov2}, 4'b1001);
        v2 = 1'b0;

        // WIDTH=8 extremes, back-to-back.
        a8 = 8'hFF; b8 = 8'h00; v8 = 1'b1;
        tick();
        check("w8_ff_00", {f8, eq8, lt8, ov8}, {model(8'hFF, 8'h00, 8), 1'b1});
        a8 = 8'h00; b8 = 8'hFF;
        tick();
        check("w8_00_ff", {f8, eq8, lt8, ov8}, {model(8'h00, 8'hFF, 8), 1'b1});
        a8 = 8'h80; b8 = 8'h7F;
        tick();
        check("w8_80_7f", {f8, eq8, lt8, ov8}, {model(8'h80, 8'h7F, 8), 1'b1});
        a8 = 8'h5A; b8 = 8'h5A;
        tick();
        check("w8_5a_5a", {f8, eq8, lt8, ov8}, 4'b0101);
        a8 = 8'h01; b8 = 8'hFE; v8 = 1'b0;
        tick();
        check("w8_hold", {f8, eq8, lt8, ov8}, 4'b0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
